// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the Game Boy memory bus arbiter.
package gb_bus_pkg;

    // Bus owner; one state lasts exactly one bus cycle.
    typedef enum logic [2:0] {
        IDLE,
        CPU,
        OAM,
        HDMA_RD,
        HDMA_WR
    } owner_state;

    // VRAM window that the HDMA target offset is mapped into.
    localparam logic [15:0] VRAM_BASE_DEFAULT = 16'h8000;

    // Value seen on read-data outputs before any read has completed.
    localparam logic [7:0]  OPEN_BUS          = 8'hFF;

endpackage

// File: rtl/bus_prio_sel.sv
// Fixed-priority selector: HDMA > OAM DMA > CPU, with CPU re-grant masking.
module bus_prio_sel
    import gb_bus_pkg::*;
(
    input  logic       hdma_req_i,
    input  logic       oam_req_i,
    input  logic       cpu_req_i,
    input  logic       cpu_mask_i,
    output owner_state owner_o
);

    // The CPU mask blocks a back-to-back grant while its ack is being issued.
    always_comb begin
        owner_o = IDLE;
        if (hdma_req_i) begin
            owner_o = HDMA_RD;
        end else if (oam_req_i) begin
            owner_o = OAM;
        end else if (cpu_req_i && !cpu_mask_i) begin
            owner_o = CPU;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus scheduler for CPU, OAM DMA and GBC HDMA.
// All bus and ack outputs are registered and change at the edge that
// enters the owning state; HDMA bytes are a read/write pair that always
// completes once started.
module mem_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE = VRAM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic        cpu_stall,

    input  logic        oam_req,
    input  logic [15:0] oam_addr,
    output logic [7:0]  oam_din,
    output logic        oam_ack,

    input  logic        hdma_rd,
    input  logic [15:0] hdma_source_addr,
    input  logic [15:0] hdma_target_addr,

    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din
);

    owner_state  state_q, state_d;
    owner_state  arb_owner;

    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q,   mem_rd_d;
    logic        mem_wr_q,   mem_wr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [7:0]  cpu_din_q,  cpu_din_d;
    logic        cpu_ack_q,  cpu_ack_d;
    logic [7:0]  oam_din_q,  oam_din_d;
    logic        oam_ack_q,  oam_ack_d;
    logic [7:0]  hdma_byte_q, hdma_byte_d;

    // Only the 8 KiB VRAM offset of the HDMA target is meaningful.
    logic        unused_tgt_hi;
    assign unused_tgt_hi = ^hdma_target_addr[15:13];

    bus_prio_sel u_prio (
        .hdma_req_i (hdma_rd),
        .oam_req_i  (oam_req),
        .cpu_req_i  (cpu_req),
        .cpu_mask_i (state_q == CPU),
        .owner_o    (arb_owner)
    );

    // Next owner and the bus/ack values that go with entering it.
    always_comb begin
        state_d     = (state_q == HDMA_RD) ? HDMA_WR : arb_owner;

        hdma_byte_d = (state_q == HDMA_RD) ? mem_din : hdma_byte_q;

        cpu_ack_d   = (state_q == CPU);
        cpu_din_d   = (state_q == CPU && !mem_wr_q) ? mem_din : cpu_din_q;
        oam_ack_d   = (state_q == OAM);
        oam_din_d   = (state_q == OAM) ? mem_din : oam_din_q;

        mem_addr_d  = 16'h0000;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_dout_d  = 8'h00;

        case (state_d)
            CPU: begin
                mem_addr_d = cpu_addr;
                mem_rd_d   = ~cpu_wr;
                mem_wr_d   = cpu_wr;
                mem_dout_d = cpu_wr ? cpu_dout : 8'h00;
            end
            OAM: begin
                mem_addr_d = oam_addr;
                mem_rd_d   = 1'b1;
            end
            HDMA_RD: begin
                mem_addr_d = hdma_source_addr;
                mem_rd_d   = 1'b1;
            end
            HDMA_WR: begin
                mem_addr_d = VRAM_BASE | {3'b000, hdma_target_addr[12:0]};
                mem_wr_d   = 1'b1;
                mem_dout_d = hdma_byte_d;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= 16'h0000;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= 8'h00;
            cpu_din_q   <= OPEN_BUS;
            cpu_ack_q   <= 1'b0;
            oam_din_q   <= OPEN_BUS;
            oam_ack_q   <= 1'b0;
            hdma_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_dout_q  <= mem_dout_d;
            cpu_din_q   <= cpu_din_d;
            cpu_ack_q   <= cpu_ack_d;
            oam_din_q   <= oam_din_d;
            oam_ack_q   <= oam_ack_d;
            hdma_byte_q <= hdma_byte_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_dout  = mem_dout_q;
    assign cpu_din   = cpu_din_q;
    assign cpu_ack   = cpu_ack_q;
    assign oam_din   = oam_din_q;
    assign oam_ack   = oam_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expected values.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_ack, cpu_stall;
    logic        oam_req;
    logic [15:0] oam_addr;
    logic [7:0]  oam_din;
    logic        oam_ack;
    logic        hdma_rd;
    logic [15:0] hdma_source_addr, hdma_target_addr;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_dout, mem_din;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.VRAM_BASE(16'h8000)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_req          (cpu_req),
        .cpu_wr           (cpu_wr),
        .cpu_addr         (cpu_addr),
        .cpu_dout         (cpu_dout),
        .cpu_din          (cpu_din),
        .cpu_ack          (cpu_ack),
        .cpu_stall        (cpu_stall),
        .oam_req          (oam_req),
        .oam_addr         (oam_addr),
        .oam_din          (oam_din),
        .oam_ack          (oam_ack),
        .hdma_rd          (hdma_rd),
        .hdma_source_addr (hdma_source_addr),
        .hdma_target_addr (hdma_target_addr),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .mem_wr           (mem_wr),
        .mem_dout         (mem_dout),
        .mem_din          (mem_din)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus outputs in one shot.
    task automatic chk_bus(input string tag, input logic [15:0] a, input logic rd,
                           input logic wr, input logic [7:0] d);
        chk({tag, ".addr"}, mem_addr, a);
        chk({tag, ".rd"},   {15'd0, mem_rd}, {15'd0, rd});
        chk({tag, ".wr"},   {15'd0, mem_wr}, {15'd0, wr});
        chk({tag, ".dout"}, {8'd0, mem_dout}, {8'd0, d});
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
        oam_req = 1'b0; oam_addr = 16'h0000;
        hdma_rd = 1'b0; hdma_source_addr = 16'h0000; hdma_target_addr = 16'h0000;
        mem_din = 8'h00;

        // Reset and idle
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk_bus("rst", 16'h0000, 1'b0, 1'b0, 8'h00);
        chk("rst.cpu_din", {8'd0, cpu_din}, 16'h00FF);
        chk("rst.oam_din", {8'd0, oam_din}, 16'h00FF);
        chk("rst.cpu_ack", {15'd0, cpu_ack}, 16'd0);
        chk("rst.oam_ack", {15'd0, oam_ack}, 16'd0);
        chk("rst.stall",   {15'd0, cpu_stall}, 16'd0);

        // CPU read C000 -> 5A
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'hC000; mem_din = 8'h5A;
        #1 chk("rd.stall0", {15'd0, cpu_stall}, 16'd1);
        tick();
        chk_bus("rd.bus", 16'hC000, 1'b1, 1'b0, 8'h00);
        chk("rd.stall1", {15'd0, cpu_stall}, 16'd1);
        chk("rd.noack",  {15'd0, cpu_ack}, 16'd0);
        tick();
        chk("rd.ack",    {15'd0, cpu_ack}, 16'd1);
        chk("rd.din",    {8'd0, cpu_din}, 16'h005A);
        chk("rd.stall2", {15'd0, cpu_stall}, 16'd0);
        chk_bus("rd.idle", 16'h0000, 1'b0, 1'b0, 8'h00);
        cpu_req = 1'b0;
        tick();
        chk("rd.ackoff", {15'd0, cpu_ack}, 16'd0);
        chk("rd.hold",   {8'd0, cpu_din}, 16'h005A);

        // CPU write 33 -> D000, request kept high through the ack
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'hD000; cpu_dout = 8'h33; mem_din = 8'h77;
        tick();
        chk_bus("wr.bus", 16'hD000, 1'b0, 1'b1, 8'h33);
        tick();
        chk("wr.ack", {15'd0, cpu_ack}, 16'd1);
        chk("wr.din", {8'd0, cpu_din}, 16'h005A);
        chk_bus("wr.noregrant", 16'h0000, 1'b0, 1'b0, 8'h00);
        tick();
        chk_bus("wr.again", 16'hD000, 1'b0, 1'b1, 8'h33);
        chk("wr.ack0", {15'd0, cpu_ack}, 16'd0);
        cpu_req = 1'b0;
        tick();
        chk("wr.ack2", {15'd0, cpu_ack}, 16'd1);
        tick();

        // HDMA for 4 cycles: two RD/WR pairs
        hdma_rd = 1'b1; hdma_source_addr = 16'h4000; hdma_target_addr = 16'h0010; mem_din = 8'hA1;
        tick();
        chk_bus("hd.rd1", 16'h4000, 1'b1, 1'b0, 8'h00);
        tick();
        chk_bus("hd.wr1", 16'h8010, 1'b0, 1'b1, 8'hA1);
        mem_din = 8'hA2;
        tick();
        chk_bus("hd.rd2", 16'h4000, 1'b1, 1'b0, 8'h00);
        tick();
        chk_bus("hd.wr2", 16'h8010, 1'b0, 1'b1, 8'hA2);
        hdma_rd = 1'b0;
        tick();
        chk_bus("hd.idle", 16'h0000, 1'b0, 1'b0, 8'h00);

        // All three together: HDMA pair, then OAM, then CPU
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'hC123;
        oam_req = 1'b1; oam_addr = 16'hC100;
        hdma_rd = 1'b1; hdma_source_addr = 16'h4100; hdma_target_addr = 16'hE020; mem_din = 8'hB7;
        tick();
        chk_bus("all.hrd", 16'h4100, 1'b1, 1'b0, 8'h00);
        chk("all.stall1", {15'd0, cpu_stall}, 16'd1);
        hdma_rd = 1'b0;
        tick();
        chk_bus("all.hwr", 16'h8020, 1'b0, 1'b1, 8'hB7);
        chk("all.stall2", {15'd0, cpu_stall}, 16'd1);
        tick();
        chk_bus("all.oam", 16'hC100, 1'b1, 1'b0, 8'h00);
        chk("all.oamack0", {15'd0, oam_ack}, 16'd0);
        chk("all.stall3", {15'd0, cpu_stall}, 16'd1);
        oam_req = 1'b0; mem_din = 8'h3C;
        tick();
        chk("all.oamack", {15'd0, oam_ack}, 16'd1);
        chk("all.oamdin", {8'd0, oam_din}, 16'h003C);
        chk_bus("all.cpu", 16'hC123, 1'b1, 1'b0, 8'h00);
        chk("all.cpuack0", {15'd0, cpu_ack}, 16'd0);
        chk("all.stall4", {15'd0, cpu_stall}, 16'd1);
        mem_din = 8'hD4;
        tick();
        chk("all.cpuack", {15'd0, cpu_ack}, 16'd1);
        chk("all.cpudin", {8'd0, cpu_din}, 16'h00D4);
        chk("all.oamack1", {15'd0, oam_ack}, 16'd0);
        chk("all.oamhold", {8'd0, oam_din}, 16'h003C);
        cpu_req = 1'b0;
        tick();

        // HDMA drops during HDMA_RD; the write still follows, then the pending CPU
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'hC200;
        hdma_rd = 1'b1; hdma_source_addr = 16'h4200; hdma_target_addr = 16'h0030; mem_din = 8'hE5;
        tick();
        chk_bus("drop.hrd", 16'h4200, 1'b1, 1'b0, 8'h00);
        hdma_rd = 1'b0;
        tick();
        chk_bus("drop.hwr", 16'h8030, 1'b0, 1'b1, 8'hE5);
        chk("drop.stall", {15'd0, cpu_stall}, 16'd1);
        tick();
        chk_bus("drop.cpu", 16'hC200, 1'b1, 1'b0, 8'h00);
        mem_din = 8'h6F;
        tick();
        chk("drop.ack", {15'd0, cpu_ack}, 16'd1);
        chk("drop.din", {8'd0, cpu_din}, 16'h006F);
        cpu_req = 1'b0;
        tick();

        // Reset asserted in the middle of an OAM cycle
        oam_req = 1'b1; oam_addr = 16'hC300; mem_din = 8'h99;
        tick();
        chk_bus("rsto.oam", 16'hC300, 1'b1, 1'b0, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        chk_bus("rsto.now", 16'h0000, 1'b0, 1'b0, 8'h00);
        tick();
        chk("rsto.noack", {15'd0, oam_ack}, 16'd0);
        chk("rsto.din",   {8'd0, oam_din}, 16'h00FF);
        oam_req = 1'b0;
        reset_n = 1'b1;
        tick();
        chk_bus("rsto.idle", 16'h0000, 1'b0, 1'b0, 8'h00);
        chk("rsto.noack2", {15'd0, oam_ack}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Fixed-priority scheduler for the shared cartridge/WRAM/VRAM memory bus. It arbitrates between three requesters: the CPU, the OAM DMA engine and the GBC HDMA engine. It sequences each HDMA byte as a source read followed by a VRAM write, and routes read data back to the winning requester. It stalls the CPU while the bus is owned by DMA. It sits between the CPU core, the DMA blocks and the memory decode.

## Interface
Parameters:
- VRAM_BASE, 16'h8000: base OR-ed onto the 13-bit HDMA target offset.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level; cpu_addr/cpu_wr/cpu_dout are held stable while high.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle pulse; access complete.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- oam_req  in  1  OAM DMA byte-read request, level.
- oam_addr  in  16  OAM DMA source address.
- oam_din  out  8  read byte; valid with oam_ack.
- oam_ack  out  1  one-cycle pulse.
- hdma_rd  in  1  HDMA active; the engine advances its count every clk.
- hdma_source_addr  in  16  HDMA source address.
- hdma_target_addr  in  16  HDMA target offset; bits [12:0] used.
- mem_addr  out  16  bus address.
- mem_rd  out  1  bus read strobe.
- mem_wr  out  1  bus write strobe.
- mem_dout  out  8  bus write data.
- mem_din  in  8  bus read data; sampled at the edge ending a read cycle.

## Operation
- Owner FSM states: IDLE, CPU, OAM, HDMA_RD, HDMA_WR. One state equals one bus cycle.
- Arbitration happens at every edge where the state is not HDMA_RD. Priority is hdma_rd > oam_req > cpu_req; if none is asserted, the next state is IDLE.
- HDMA_RD
  - mem_addr = hdma_source_addr, mem_rd = 1.
  - mem_din is latched into the HDMA byte register.
  - The next state is always HDMA_WR, even if hdma_rd has dropped; the pair always completes.
- HDMA_WR
  - mem_addr = VRAM_BASE | hdma_target_addr[12:0], mem_wr = 1, mem_dout = latched byte.
  - The next state is then arbitrated normally. HDMA therefore re-wins while hdma_rd stays high.
- OAM
  - mem_addr = oam_addr, mem_rd = 1.
  - At the next edge: oam_din <= mem_din, oam_ack = 1 for one cycle.
- CPU
  - mem_addr = cpu_addr, mem_rd = ~cpu_wr, mem_wr = cpu_wr, mem_dout = cpu_dout.
  - At the next edge: cpu_ack = 1 for one cycle; cpu_din <= mem_din on reads and is held on writes.
  - The CPU is not re-granted in the cycle its ack is high. If cpu_req is still high after that, it is treated as a new access.
- Write data: mem_dout is 8'h00 whenever mem_wr = 0.
- cpu_din and oam_din hold their value until the next ack.
- No fairness mechanism: a continuous HDMA or OAM request starves the CPU. This is intentional and matches hardware behaviour.

## Timing
- Registered outputs: mem_addr, mem_rd, mem_wr, mem_dout, cpu_din, cpu_ack, oam_din, oam_ack. All are updated at the edge that enters the state.
- Reset values:
  - state IDLE.
  - mem_addr 16'h0000, mem_rd 0, mem_wr 0, mem_dout 8'h00.
  - cpu_din 8'hFF, oam_din 8'hFF, cpu_ack 0, oam_ack 0.
  - HDMA byte register 8'h00.
- Latency:
  - A request sampled high at edge N in IDLE owns the bus during cycle N..N+1.
  - Its ack is high during cycle N+1..N+2.
- HDMA throughput: one byte per 2 cycles. This matches the engine's 2-counts-per-byte address stepping; addresses are taken live, with no internal counters.
- Simultaneous requests: the highest priority wins. Losers stay pending, with no ack and cpu_stall still high.
- hdma_rd rising during HDMA_RD/HDMA_WR of a previous run: handled as a continuation.
- hdma_rd rising mid-OAM or mid-CPU: the current cycle completes, then HDMA wins.
- reset_n low mid-access: everything returns to reset values immediately; a pending ack is lost. Requesters must reissue.

## Structure
- Shared package gb_bus_pkg:
  - owner_state enum (IDLE, CPU, OAM, HDMA_RD, HDMA_WR).
  - VRAM_BASE default constant.
  - OPEN_BUS = 8'hFF.
- One natural sub-module: bus_prio_sel, a combinational 3-input fixed-priority selector returning the next owner. It contains the "no CPU re-grant during its ack" mask.

## Test plan
- Reset then idle → all outputs at reset values. CPU read at 16'hC000 with mem_din = 8'h5A → mem_rd for 1 cycle, then cpu_ack with cpu_din = 8'h5A; cpu_stall high only for those 2 cycles.
- CPU write 8'h33 to 16'hD000 → one cycle with mem_wr = 1, mem_dout = 8'h33; then cpu_ack; cpu_din unchanged.
- hdma_rd high for 4 cycles, source 16'h4000, target 16'h0010, bus returns 8'hA1 → HDMA_RD at 16'h4000, then HDMA_WR at 16'h8010 with data 8'hA1; two pairs in total.
- cpu_req and oam_req and hdma_rd all asserted together → HDMA pair first, then OAM, then CPU; acks in that order; CPU stalled throughout.
- hdma_rd drops during HDMA_RD → HDMA_WR still issued, then bus returns to the pending CPU.
- reset_n asserted during OAM cycle → mem_rd drops immediately, no oam_ack, state IDLE.
